// File: rtl/alu_operand_loader_if.sv
// Byte stream in, atomic operand set out: the loader's link to its feeder and to the arithmetic unit.
`timescale 1ns/1ps
interface alu_operand_loader_if #(
  parameter int M = 32
);
  logic [7:0]   i_data;
  logic         i_valid;
  logic         o_ready;
  logic [M-1:0] o_arg_A;
  logic [M-1:0] o_arg_B;
  logic [3:0]   o_op;
  logic         o_issue;
  logic         o_busy;
  logic         o_frame_err;

  modport master (
    output i_data, i_valid,
    input  o_ready, o_arg_A, o_arg_B, o_op, o_issue, o_busy, o_frame_err
  );

  modport slave (
    input  i_data, i_valid,
    output o_ready, o_arg_A, o_arg_B, o_op, o_issue, o_busy, o_frame_err
  );
endinterface

// File: rtl/alu_operand_loader.sv
// Assembles header + operand A + operand B from a byte stream into shadow registers and
// hands the full set to the arithmetic unit in one edge, followed by a one-cycle issue strobe.
`timescale 1ns/1ps
module alu_operand_loader #(
  parameter int M       = 32,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              i_reset,
  alu_operand_loader_if.slave bus
);
  localparam int NB = M / 8;
  localparam int CW = $clog2(NB) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, ISSUE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] gap;
  logic [M-1:0]  sh_a;
  logic [M-1:0]  sh_b;
  logic [M-1:0]  next_a;
  logic [M-1:0]  next_b;
  logic [3:0]    sh_op;
  logic          take;
  logic          last;
  logic          expire;

  assign bus.o_ready = (state != ISSUE);
  assign take        = bus.i_valid && bus.o_ready;
  assign last        = (cnt == CW'(NB - 1));
  assign expire      = !take && (gap == TW'(TIMEOUT - 1));

  // Shadow values with the current byte merged in, so the last B byte can go straight to the outputs.
  always_comb begin
    next_a = sh_a;
    next_b = sh_b;
    for (int unsigned k = 0; k < NB; k++) begin
      if (cnt == CW'(k)) begin
        next_a[8*k +: 8] = bus.i_data;
        next_b[8*k +: 8] = bus.i_data;
      end
    end
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state           <= IDLE;
      cnt             <= '0;
      gap             <= '0;
      sh_a            <= '0;
      sh_b            <= '0;
      sh_op           <= '0;
      bus.o_arg_A     <= '0;
      bus.o_arg_B     <= '0;
      bus.o_op        <= '0;
      bus.o_issue     <= 1'b0;
      bus.o_busy      <= 1'b0;
      bus.o_frame_err <= 1'b0;
    end else begin
      bus.o_issue     <= 1'b0;
      bus.o_frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take) begin
            if (bus.i_data[7:4] == 4'hA) begin
              sh_op      <= bus.i_data[3:0];
              state      <= LOAD_A;
              bus.o_busy <= 1'b1;
              cnt        <= '0;
              gap        <= '0;
            end else begin
              bus.o_frame_err <= 1'b1;
            end
          end
        end
        LOAD_A, LOAD_B: begin
          if (take) begin
            gap <= '0;
            cnt <= last ? '0 : cnt + CW'(1);
            if (state == LOAD_A) begin
              sh_a <= next_a;
              if (last) state <= LOAD_B;
            end else begin
              sh_b <= next_b;
              if (last) begin
                bus.o_arg_A <= sh_a;
                bus.o_arg_B <= next_b;
                bus.o_op    <= sh_op;
                bus.o_issue <= 1'b1;
                state       <= ISSUE;
              end
            end
          end else if (expire) begin
            // Abandon the frame; published operands are left untouched.
            state           <= IDLE;
            bus.o_busy      <= 1'b0;
            bus.o_frame_err <= 1'b1;
            cnt             <= '0;
            gap             <= '0;
            sh_a            <= '0;
            sh_b            <= '0;
            sh_op           <= '0;
          end else begin
            gap <= gap + TW'(1);
          end
        end
        ISSUE: begin
          state      <= IDLE;
          bus.o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Byte-serial command front end that sits directly upstream of the synchronous arithmetic unit. It receives one command frame per operation over an 8-bit valid/ready stream: a header byte carrying the opcode, then operand A, then operand B. It assembles the frame in shadow registers and presents the complete `iarg_A`/`iarg_B`/`iop` set to the arithmetic unit atomically, with a one-cycle issue strobe. Downstream capture logic samples the unit's `o_result`/`o_status` on the cycle after the strobe.

## Interface
- `M`, default 32: operand width; must be a multiple of 8; `NB = M/8` bytes per operand.
- `TIMEOUT`, default 255: maximum idle cycles allowed between bytes inside a frame.
- `clk`, in, 1: single clock; all logic on rising edge.
- `i_reset`, in, 1: reset, asynchronous and active-low.
- `i_data`, in, 8: stream byte.
- `i_valid`, in, 1: `i_data` valid.
- `o_ready`, out, 1: loader accepts a byte this cycle.
- `o_arg_A`, out, M: operand A to the arithmetic unit `iarg_A`.
- `o_arg_B`, out, M: operand B to the arithmetic unit `iarg_B`.
- `o_op`, out, 4: opcode to the arithmetic unit `iop`.
- `o_issue`, out, 1: one-cycle pulse; new operand set is on the outputs this cycle.
- `o_busy`, out, 1: a frame is in progress (state other than IDLE).
- `o_frame_err`, out, 1: one-cycle pulse on a bad header or a timeout.

## Operation
- A byte is accepted on a rising edge where `i_valid && o_ready`. No byte is accepted while `i_reset` is low.
- Frame layout: header, then NB bytes of A (LSB first), then NB bytes of B (LSB first).
- Header: `[7:4]` must be 4'hA; `[3:0]` is the opcode. Opcodes are passed unchecked; illegal codes are flagged by the arithmetic unit, not here.
- States:
  - IDLE:
    - Valid header → LOAD_A, with the opcode latched to the shadow.
    - Bad header → byte discarded, `o_frame_err` pulses, stay in IDLE.
  - LOAD_A: accepted byte k (0..NB-1) is written to shadow A bits `[8k+7:8k]`. After byte NB-1 → LOAD_B.
  - LOAD_B: same for shadow B. On acceptance of byte NB-1, the shadow op, A and B are copied to `o_op`, `o_arg_A` and `o_arg_B` on that same edge; → ISSUE.
  - ISSUE: `o_issue` = 1 for this one cycle; `o_ready` = 0; → IDLE unconditionally.
- `o_ready` = 1 in IDLE, LOAD_A and LOAD_B; 0 in ISSUE.
- `o_busy` = 1 in LOAD_A, LOAD_B and ISSUE.
- Outputs `o_arg_A`, `o_arg_B` and `o_op` change only at the ISSUE-entry edge and hold between frames. A partial frame never alters them.
- Byte counter: width `$clog2(NB)+1`; cleared on every state change.
- Timeout counter:
  - Active in LOAD_A and LOAD_B.
  - Cleared on each accepted byte and on state entry.
  - Increments on each cycle with no accepted byte.
  - On reaching TIMEOUT: → IDLE, `o_frame_err` pulses, shadow discarded, outputs unchanged.
- Simultaneous events:
  - A byte accepted on the same edge the counter would reach TIMEOUT is taken and the counter clears; no error.
  - A new header offered during ISSUE is held off by `o_ready` = 0.
- Reset (asynchronous, any time, including mid-frame):
  - State → IDLE; all counters and shadows → 0.
  - `o_arg_A`, `o_arg_B` and `o_op` → 0; `o_issue`, `o_frame_err` and `o_busy` → 0.
  - Any partial frame is lost.

## Timing
- `o_issue`, `o_frame_err`, `o_busy` and all operand outputs are registered. `o_ready` is decoded from the state register.
- Latency:
  - The operand outputs update on the edge that accepts the last B byte.
  - `o_issue` is high in the following cycle.
  - The arithmetic unit registers on the edge ending that cycle.
  - Result and status are valid in the cycle after `o_issue`.
- Minimum frame period: `1 + 2·NB + 1` cycles. For M=32 that is 10 cycles: 9 accept cycles plus 1 ISSUE cycle.
- `o_frame_err` for a bad header is high in the cycle after the header edge.
- Timeout fires on the edge where the gap count equals TIMEOUT.

## Test plan
- **Basic frame.** M=32. Stream A2, 78, 56, 34, 12, 04, 00, 00, 00 back-to-back. Required: `o_arg_A` = 0x12345678, `o_arg_B` = 0x00000004, `o_op` = 2; `o_issue` pulses exactly once, in the cycle after the 9th byte; `o_ready` = 0 during that cycle.
- **Bad header.** Send 0x53, then a valid frame A0 + 8 bytes. Required: one `o_frame_err` pulse after the 0x53; the outputs reflect only the second frame; `o_busy` = 0 after the 0x53.
- **Valid gaps.** Deassert `i_valid` for 5 cycles between each operand byte. Required: outputs stay unchanged until the last byte; then one `o_issue`; no error.
- **Timeout.** TIMEOUT=16. Send A1, 11, 22, then idle 16 cycles. Required: `o_frame_err` pulses; state returns to IDLE; `o_arg_*` keep the previous frame's values; no `o_issue`.
- **Async reset mid-frame.** After A3 plus 3 A bytes, pulse `i_reset` low asynchronously between edges. Required: all outputs read 0 immediately. A following complete frame A3, 01,00,00,00, 02,00,00,00 produces `o_arg_A` = 1, `o_arg_B` = 2, `o_op` = 3.
- **Back-to-back frames with the arithmetic unit attached.** Send two frames with no gap. Required: the second header is stalled exactly one cycle (ISSUE); each frame produces one `o_issue`; the unit's result matches the respective frame one cycle later.
